// File: rtl/rtc_bus_responder_if.sv
// Strobe/status bundle between the RTC bus master and the responder.
// The data bus itself is a plain inout port on the responder.
interface rtc_bus_responder_if;
  logic       CS;
  logic       WR;
  logic       RD;
  logic       AD;
  logic       tick_1hz;
  logic       bus_oe;
  logic [7:0] addr_latched;

  modport master (
    output CS, WR, RD, AD, tick_1hz,
    input  bus_oe, addr_latched
  );

  modport slave (
    input  CS, WR, RD, AD, tick_1hz,
    output bus_oe, addr_latched
  );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC chip stand-in: multiplexed address/data bus, small RAM,
// BCD hh:mm:ss advanced by a 1 Hz enable.
module rtc_bus_responder #(
  parameter logic [7:0] ADDR_SEC  = 8'h21,
  parameter logic [7:0] ADDR_MIN  = 8'h22,
  parameter logic [7:0] ADDR_HOUR = 8'h23,
  parameter int         RAM_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  rtc_bus_responder_if.slave bus,
  inout  wire  [7:0]       Bus_Dato_Dire
);

  localparam int         AW      = $clog2(RAM_DEPTH);
  localparam logic [7:0] RAM_TOP = 8'(RAM_DEPTH);

  logic       cs_q, wr_q, rd_q, ad_q;
  logic       cs_qq, wr_qq, rd_qq;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic       pend_q, pend_d;
  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] ram_d [RAM_DEPTH];

  logic       commit;
  logic       oe;
  logic       oe_next;
  logic       adv;
  logic [7:0] rd_mux;
  logic [8:0] s_inc, m_inc, h_inc;

  // Values at or past the limit (incl. invalid BCD) wrap to 00 with carry.
  function automatic logic [8:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (v >= lim) return 9'h100;
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {1'b0, hi, lo};
  endfunction

  // rd_qq high excludes the RD+WR protocol error.
  assign commit  = wr_q & ~wr_qq & ~cs_qq & rd_qq;
  assign oe      = ~cs_q & ~rd_q & ad_q & wr_q;
  assign oe_next = ~bus.CS & ~bus.RD & bus.AD & bus.WR;

  assign bus.bus_oe       = oe;
  assign bus.addr_latched = addr_q;
  assign Bus_Dato_Dire    = oe ? rdata_q : 8'hzz;

  always_comb begin
    rd_mux = 8'hFF;
    unique case (1'b1)
      (addr_q < RAM_TOP):    rd_mux = ram_q[addr_q[AW-1:0]];
      (addr_q == ADDR_SEC):  rd_mux = sec_q;
      (addr_q == ADDR_MIN):  rd_mux = min_q;
      (addr_q == ADDR_HOUR): rd_mux = hour_q;
      default:               rd_mux = 8'hFF;
    endcase
  end

  always_comb begin
    wdat_d  = bus.WR ? wdat_q : Bus_Dato_Dire;
    rdata_d = (oe_next & ~oe) ? rd_mux : rdata_q;
    addr_d  = addr_q;
    ram_d   = ram_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    pend_d  = pend_q;
    adv     = 1'b0;
    s_inc   = bcd_inc(sec_q, 8'h59);
    m_inc   = bcd_inc(min_q, 8'h59);
    h_inc   = bcd_inc(hour_q, 8'h23);

    if (commit) begin
      pend_d = pend_q | bus.tick_1hz;
      if (!ad_q) begin
        addr_d = wdat_q;
      end else begin
        unique case (1'b1)
          (addr_q < RAM_TOP):    ram_d[addr_q[AW-1:0]] = wdat_q;
          (addr_q == ADDR_SEC):  sec_d  = wdat_q;
          (addr_q == ADDR_MIN):  min_d  = wdat_q;
          (addr_q == ADDR_HOUR): hour_d = wdat_q;
          default:               ;
        endcase
      end
    end else begin
      adv    = pend_q | bus.tick_1hz;
      pend_d = 1'b0;
    end

    if (adv) begin
      sec_d = s_inc[7:0];
      if (s_inc[8]) begin
        min_d = m_inc[7:0];
        if (m_inc[8]) hour_d = h_inc[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      ad_q    <= 1'b0;
      cs_qq   <= 1'b1;
      wr_qq   <= 1'b1;
      rd_qq   <= 1'b1;
      wdat_q  <= 8'h00;
      addr_q  <= 8'h00;
      rdata_q <= 8'h00;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hour_q  <= 8'h00;
      pend_q  <= 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
    end else begin
      cs_q    <= bus.CS;
      wr_q    <= bus.WR;
      rd_q    <= bus.RD;
      ad_q    <= bus.AD;
      cs_qq   <= cs_q;
      wr_qq   <= wr_q;
      rd_qq   <= rd_q;
      wdat_q  <= wdat_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      pend_q  <= pend_d;
      ram_q   <= ram_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed bus cycles, read data
// checked by a scoreboard monitor on each bus_oe assertion.
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] Bus_Dato_Dire;

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] exp_q [$];
  logic [7:0] cur_exp;
  logic       oe_prev = 1'b0;

  rtc_bus_responder_if bif ();

  rtc_bus_responder dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bif.slave),
    .Bus_Dato_Dire (Bus_Dato_Dire)
  );

  assign Bus_Dato_Dire = drv_en ? drv_val : 8'hzz;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
  endtask

  // Scoreboard monitor: pop on bus_oe rise, compare every oe cycle.
  always @(negedge clk) begin
    if (!reset && bif.bus_oe) begin
      if (!oe_prev) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL rd_unexpected: got %02h expected none",
                   Bus_Dato_Dire);
          cur_exp = 8'hxx;
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (cur_exp !== 8'hxx) chk("rd_data", Bus_Dato_Dire, cur_exp);
    end
    oe_prev = bif.bus_oe;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic ad, input logic [7:0] v,
                        input logic tk);
    bif.AD = ad;
    drv_val = v;
    drv_en = 1'b1;
    bif.CS = 1'b0;
    bif.WR = 1'b0;
    clk_n(2);
    bif.WR = 1'b1;
    clk_n(1);
    drv_en = 1'b0;
    bif.CS = 1'b1;
    bif.tick_1hz = tk;
    clk_n(1);
    bif.tick_1hz = 1'b0;
    clk_n(2);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    bus_wr(1'b0, a, 1'b0);
    bus_wr(1'b1, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] e);
    bus_wr(1'b0, a, 1'b0);
    chk("addr_latched", bif.addr_latched, a);
    exp_q.push_back(e);
    bif.AD = 1'b1;
    bif.CS = 1'b0;
    bif.RD = 1'b0;
    @(negedge clk);
    chk("oe_before", {7'd0, bif.bus_oe}, 8'h00);
    @(negedge clk);
    chk("oe_latency", {7'd0, bif.bus_oe}, 8'h01);
    clk_n(2);
    bif.RD = 1'b1;
    bif.CS = 1'b1;
    @(negedge clk);
    chk("oe_hold", {7'd0, bif.bus_oe}, 8'h01);
    @(negedge clk);
    chk("oe_release", {7'd0, bif.bus_oe}, 8'h00);
    clk_n(1);
  endtask

  task automatic tick();
    bif.tick_1hz = 1'b1;
    clk_n(1);
    bif.tick_1hz = 1'b0;
    clk_n(1);
  endtask

  initial begin
    reset = 1'b1;
    drv_en = 1'b0;
    drv_val = 8'h00;
    bif.CS = 1'b1;
    bif.WR = 1'b1;
    bif.RD = 1'b1;
    bif.AD = 1'b0;
    bif.tick_1hz = 1'b0;
    clk_n(3);
    chk("rst_oe", {7'd0, bif.bus_oe}, 8'h00);
    chk("rst_addr", bif.addr_latched, 8'h00);
    reset = 1'b0;
    clk_n(2);

    rd_reg(8'h21, 8'h00);
    rd_reg(8'h22, 8'h00);
    rd_reg(8'h23, 8'h00);

    wr_reg(8'h05, 8'hA7);
    rd_reg(8'h05, 8'hA7);
    wr_reg(8'h0F, 8'h3C);
    rd_reg(8'h0F, 8'h3C);
    rd_reg(8'h05, 8'hA7);

    wr_reg(8'h21, 8'h59);
    wr_reg(8'h22, 8'h59);
    wr_reg(8'h23, 8'h23);
    tick();
    rd_reg(8'h21, 8'h00);
    rd_reg(8'h22, 8'h00);
    rd_reg(8'h23, 8'h00);

    wr_reg(8'h21, 8'h5A);
    tick();
    rd_reg(8'h21, 8'h00);
    rd_reg(8'h22, 8'h01);

    wr_reg(8'h22, 8'h09);
    tick();
    rd_reg(8'h22, 8'h09);
    rd_reg(8'h21, 8'h01);

    bus_wr(1'b0, 8'h21, 1'b0);
    bus_wr(1'b1, 8'h09, 1'b1);
    rd_reg(8'h21, 8'h10);

    rd_reg(8'h40, 8'hFF);
    wr_reg(8'h40, 8'h12);
    rd_reg(8'h40, 8'hFF);

    bus_wr(1'b0, 8'h06, 1'b0);
    bif.AD = 1'b1;
    drv_val = 8'h55;
    drv_en = 1'b1;
    bif.CS = 1'b0;
    bif.WR = 1'b0;
    bif.RD = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("err_oe", {7'd0, bif.bus_oe}, 8'h00);
    clk_n(2);
    bif.WR = 1'b1;
    bif.RD = 1'b1;
    drv_en = 1'b0;
    clk_n(1);
    bif.CS = 1'b1;
    clk_n(2);
    rd_reg(8'h06, 8'h00);

    bus_wr(1'b0, 8'h05, 1'b0);
    exp_q.push_back(8'hA7);
    bif.AD = 1'b1;
    bif.CS = 1'b0;
    bif.RD = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_oe", {7'd0, bif.bus_oe}, 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_oe", {7'd0, bif.bus_oe}, 8'h00);
    chk("rst_mid_addr", bif.addr_latched, 8'h00);
    bif.CS = 1'b1;
    bif.RD = 1'b1;
    clk_n(1);
    reset = 1'b0;
    clk_n(1);
    rd_reg(8'h05, 8'h00);
    rd_reg(8'h21, 8'h00);

    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
